instmem_fetch: RTL and testbench
================================

INSTMEM_FETCH -- requirements
Module: instmem_fetch

Interface
REQ-001 Parameter INST_WIDTH, default 8: instruction word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 6: width of ld_addr, req_addr and rsp_addr.
REQ-003 Parameter DEPTH, default 64: number of stored words; DEPTH SHALL be at most 2^ADDR_WIDTH.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 prog_mode  in  1  1 = program-load mode, 0 = fetch mode.
REQ-007 ld_en  in  1  write strobe for the program-load port.
REQ-008 ld_addr  in  ADDR_WIDTH  word address for the program load.
REQ-009 ld_data  in  INST_WIDTH  instruction word to write.
REQ-010 req_valid  in  1  fetch request is valid.
REQ-011 req_ready  out  1  fetch request can be accepted.
REQ-012 req_addr  in  ADDR_WIDTH  fetch word address.
REQ-013 flush  in  1  discards all accepted fetches that have not been popped.
REQ-014 rsp_valid  out  1  response at the head of the response FIFO is valid.
REQ-015 rsp_ready  in  1  consumer pops the head response.
REQ-016 rsp_data  out  INST_WIDTH  fetched instruction.
REQ-017 rsp_addr  out  ADDR_WIDTH  address that produced rsp_data.
REQ-018 rsp_err  out  1  address was out of range (req_addr >= DEPTH).

Function
REQ-019 FSM states: LOAD and RUN; LOAD->RUN when prog_mode=0; RUN->LOAD when prog_mode=1.
REQ-020 On a RUN->LOAD transition, the block SHALL perform an implicit flush.
REQ-021 In LOAD, ld_en=1 with ld_addr<DEPTH writes ld_data to that word at the clock edge.
REQ-022 A write with ld_addr>=DEPTH, or any ld_en pulse while in RUN, SHALL be ignored.
REQ-023 req_ready = (state==RUN) and (occ<2), where occ counts accepted requests that have not been popped.
REQ-024 req_ready is independent of rsp_ready; there is no bypass path.
REQ-025 Handshake: a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-026 Handshake: req_addr is sampled only on that edge.
REQ-027 Read latency: a request accepted at edge N SHALL be visible as a response from edge N+1 onward (1-cycle latency).
REQ-028 Read path: the memory read is synchronous; words are registered into a 2-entry in-order response FIFO.
REQ-029 Pop: a response is popped on an edge where rsp_valid and rsp_ready are both 1.
REQ-030 Stability: rsp_data, rsp_addr and rsp_err SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-031 Occupancy: accept and pop on the same edge SHALL leave occ unchanged.
REQ-032 Throughput: with rsp_ready held at 1, sustained throughput SHALL be one fetch per cycle.
REQ-033 Out-of-range: req_addr>=DEPTH is accepted normally and returns rsp_err=1 with rsp_data=0.
REQ-034 Flush: flush=1 SHALL empty the FIFO at that edge (occ=0, rsp_valid=0 next cycle).
REQ-035 Flush: a request handshaken on the same edge as flush SHALL be discarded; any pop on that edge is a don't-care.
REQ-036 Read-during-write cannot occur, because loads and fetches are mutually exclusive by state.

Reset
REQ-037 On rst=1, the following SHALL take effect immediately, independent of clk: state=LOAD, occ=0, FIFO pointers=0.
REQ-038 Output reset values: rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, req_ready=0.
REQ-039 Memory contents SHALL NOT be cleared by reset.
REQ-040 Reset during a pending fetch SHALL drop that fetch silently.

Configuration
REQ-041 Macro INSTMEM_PARITY_EN: when defined, each stored word carries an even-parity bit computed at load time.
REQ-042 With INSTMEM_PARITY_EN defined, parity is checked on read, and an output rsp_perr (out, 1) is high with the response when the stored parity mismatches; rsp_perr resets to 0.
REQ-043 When INSTMEM_PARITY_EN is undefined, no parity storage and no rsp_perr port exist; all other behaviour is identical.

Verification
REQ-044 Load: LOAD with ld_addr=0..3 and ld_data=8'h11,22,33,44; RUN, fetch 2 -> rsp_data=8'h33, rsp_addr=2, rsp_err=0, one cycle after accept.
REQ-045 Streaming: rsp_ready=1 with fetches 0,1,2,3 back-to-back -> four responses on consecutive cycles in order; req_ready stays 1.
REQ-046 Backpressure: rsp_ready=0 with three fetches offered -> two accepted, then req_ready=0; raising rsp_ready -> responses 8'h11,8'h22, then the third request is accepted.
REQ-047 Out-of-range: DEPTH=64 and fetch address 63 then 6'd63 with DEPTH=48 build -> build with DEPTH=48 returns rsp_err=1, rsp_data=0.
REQ-048 Flush and reset: with two responses queued, pulse flush together with a new handshake -> rsp_valid=0 next cycle and no response appears; assert rst mid-stream -> outputs at reset values asynchronously, state LOAD.
REQ-049 Parity (INSTMEM_PARITY_EN): force-flip one stored bit of word 1 -> fetch 1 returns rsp_perr=1; fetch 0 returns rsp_perr=0.

Source files
------------

// File: rtl/instmem_fetch.sv
// Instruction memory with a program-load port and a 2-deep fetch response FIFO.
// Optional even parity per stored word: define INSTMEM_PARITY_EN.
module instmem_fetch #(
  parameter int INST_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_mode,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [INST_WIDTH-1:0] ld_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [INST_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err
`ifdef INSTMEM_PARITY_EN
  ,
  output logic                  rsp_perr
`endif
);

`ifdef INSTMEM_PARITY_EN
  localparam int MW = INST_WIDTH + 1;
`else
  localparam int MW = INST_WIDTH;
`endif
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {LOAD, RUN} state_t;

  state_t                state;
  logic [1:0]            occ;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [MW-1:0]         mem [DEPTH];
  logic [MW-1:0]         fifo_word [2];
  logic [ADDR_WIDTH-1:0] fifo_addr [2];
  logic                  fifo_err [2];

  logic          ld_hit;
  logic          req_in_range;
  logic          drop;
  logic          accept;
  logic          pop;
  logic [MW-1:0] rd_word;
  logic [MW-1:0] head_word;
  logic [MW-1:0] ld_word;

  assign ld_hit = ld_en && (state == LOAD)
                  && ({1'b0, ld_addr} < DEPTH_L);
  assign req_in_range = {1'b0, req_addr} < DEPTH_L;
  // Leaving RUN discards queued fetches just like an explicit flush.
  assign drop = flush || ((state == RUN) && prog_mode);
  assign req_ready = (state == RUN) && (occ != 2'd2);
  assign accept = req_valid && req_ready && !drop;
  assign rsp_valid = (occ != 2'd0);
  assign pop = rsp_valid && rsp_ready;

`ifdef INSTMEM_PARITY_EN
  assign ld_word = {^ld_data, ld_data};
`else
  assign ld_word = ld_data;
`endif

  assign rd_word = req_in_range ? mem[req_addr[IW-1:0]] : '0;
  assign head_word = fifo_word[rd_ptr];

  // Outputs are gated so they read zero whenever the FIFO is empty.
  assign rsp_data = rsp_valid ? head_word[INST_WIDTH-1:0] : '0;
  assign rsp_addr = rsp_valid ? fifo_addr[rd_ptr] : '0;
  assign rsp_err  = rsp_valid && fifo_err[rd_ptr];
`ifdef INSTMEM_PARITY_EN
  assign rsp_perr = rsp_valid && (^head_word);
`endif

  // Program-load writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_hit) mem[ld_addr[IW-1:0]] <= ld_word;
  end

  // Synchronous read of the accepted address into the FIFO slot.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_word[wr_ptr] <= rd_word;
      fifo_addr[wr_ptr] <= req_addr;
      fifo_err[wr_ptr]  <= !req_in_range;
    end
  end

  // Mode FSM plus FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= LOAD;
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      unique case (state)
        LOAD: if (!prog_mode) state <= RUN;
        RUN:  if (prog_mode)  state <= LOAD;
        default: state <= LOAD;
      endcase
      if (drop) begin
        occ    <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (accept) wr_ptr <= ~wr_ptr;
        if (pop)    rd_ptr <= ~rd_ptr;
        unique case ({accept, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instmem_fetch.sv
// Scoreboard bench for instmem_fetch: default build plus a DEPTH=48 copy
// driven by the same inputs for the out-of-range case.
module tb_instmem_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_mode;
  logic       ld_en;
  logic [5:0] ld_addr;
  logic [7:0] ld_data;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_addr;
  logic       flush;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [5:0] rsp_addr;
  logic       rsp_err;
  logic       req_ready48;
  logic       rsp_valid48;
  logic [7:0] rsp_data48;
  logic [5:0] rsp_addr48;
  logic       rsp_err48;
`ifdef INSTMEM_PARITY_EN
  logic       rsp_perr;
  logic       rsp_perr48;
`endif

  always #5 clk = ~clk;

  instmem_fetch dut (
    .clk(clk), .rst(rst), .prog_mode(prog_mode),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rsp_err(rsp_err)
`ifdef INSTMEM_PARITY_EN
    , .rsp_perr(rsp_perr)
`endif
  );

  instmem_fetch #(.DEPTH(48)) dut48 (
    .clk(clk), .rst(rst), .prog_mode(prog_mode),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready48),
    .req_addr(req_addr), .flush(flush),
    .rsp_valid(rsp_valid48), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data48), .rsp_addr(rsp_addr48),
    .rsp_err(rsp_err48)
`ifdef INSTMEM_PARITY_EN
    , .rsp_perr(rsp_perr48)
`endif
  );

  typedef struct packed {
    logic [7:0] data;
    logic [5:0] addr;
    logic       err;
    logic       perr;
  } exp_t;

  exp_t       sb[$];
  exp_t       head;
  logic [7:0] model [64];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int a);
    exp_t e;
    e.data = model[a];
    e.addr = 6'(a);
    e.err  = 1'b0;
    e.perr = 1'b0;
    return e;
  endfunction

  // Monitor: every pop is matched against the oldest expected response.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=%0h required=none",
                 rsp_addr);
      end else begin
        head = sb.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(head.data));
        chk("rsp_addr", 32'(rsp_addr), 32'(head.addr));
        chk("rsp_err", 32'(rsp_err), 32'(head.err));
`ifdef INSTMEM_PARITY_EN
        chk("rsp_perr", 32'(rsp_perr), 32'(head.perr));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [7:0] d);
    ld_en = 1'b1;
    ld_addr = 6'(a);
    ld_data = d;
    tick();
    ld_en = 1'b0;
    model[a] = d;
  endtask

  // Offer one fetch that is known to be accepted this cycle.
  task automatic fetch(input int a, input string name);
    req_valid = 1'b1;
    req_addr = 6'(a);
    @(negedge clk);
    chk(name, 32'(req_ready), 32'd1);
    sb.push_back(mk(a));
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    rst = 1'b1;
    prog_mode = 1'b1;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    req_valid = 1'b0;
    req_addr = '0;
    flush = 1'b0;
    rsp_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_addr", 32'(rsp_addr), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    load(0, 8'h11);
    load(1, 8'h22);
    load(2, 8'h33);
    load(3, 8'h44);
    load(63, 8'hA5);
    prog_mode = 1'b0;
    tick();

    // Load strobe in RUN must not overwrite word 0.
    ld_en = 1'b1;
    ld_addr = 6'd0;
    ld_data = 8'hFF;
    tick();
    ld_en = 1'b0;

    // One-cycle latency for a single fetch of word 2.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = 6'd2;
    @(negedge clk);
    chk("lat_ready", 32'(req_ready), 32'd1);
    chk("lat_pre", 32'(rsp_valid), 32'd0);
    sb.push_back(mk(2));
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("lat_post", 32'(rsp_valid), 32'd1);
    tick();

    // Back-to-back streaming with the consumer always ready.
    for (int i = 0; i < 5; i++) begin
      req_valid = (i < 4);
      req_addr = 6'(i % 4);
      @(negedge clk);
      if (i < 4) begin
        chk("stream_ready", 32'(req_ready), 32'd1);
        sb.push_back(mk(i));
      end
      if (i > 0) chk("stream_valid", 32'(rsp_valid), 32'd1);
      tick();
    end
    req_valid = 1'b0;
    tick();

    // Backpressure: two accepted, third waits for a pop.
    rsp_ready = 1'b0;
    fetch(0, "bp_acc0");
    fetch(1, "bp_acc1");
    req_valid = 1'b1;
    req_addr = 6'd2;
    @(negedge clk);
    chk("bp_full", 32'(req_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("bp_full2", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_bypass", 32'(req_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("bp_resume", 32'(req_ready), 32'd1);
    sb.push_back(mk(2));
    tick();
    req_valid = 1'b0;
    tick();
    tick();

    // Top address: in range for DEPTH=64, error for DEPTH=48.
    rsp_ready = 1'b0;
    fetch(63, "oor_acc");
    @(negedge clk);
    chk("d48_valid", 32'(rsp_valid48), 32'd1);
    chk("d48_err", 32'(rsp_err48), 32'd1);
    chk("d48_data", 32'(rsp_data48), 32'd0);
    chk("d48_addr", 32'(rsp_addr48), 32'd63);
    tick();
    @(negedge clk);
    chk("hold_data", 32'(rsp_data), 32'hA5);
    chk("hold_err", 32'(rsp_err), 32'd0);
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Flush with two responses queued.
    fetch(1, "fl_acc0");
    fetch(3, "fl_acc1");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_empty", 32'(rsp_valid), 32'd0);
    tick();

    // Flush together with a handshake: the new request is discarded too.
    fetch(2, "fl2_acc0");
    req_valid = 1'b1;
    req_addr = 6'd0;
    flush = 1'b1;
    @(negedge clk);
    chk("fl2_hs_ready", 32'(req_ready), 32'd1);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_hs_empty", 32'(rsp_valid), 32'd0);
    tick();
    rsp_ready = 1'b1;
    tick();
    tick();
    rsp_ready = 1'b0;

    // Leaving RUN drops pending fetches.
    fetch(1, "impl_acc");
    prog_mode = 1'b1;
    tick();
    sb.delete();
    @(negedge clk);
    chk("impl_flush", 32'(rsp_valid), 32'd0);
    chk("impl_load_rdy", 32'(req_ready), 32'd0);
    prog_mode = 1'b0;
    tick();

    // Asynchronous reset in the middle of queued traffic.
    fetch(0, "rst_acc0");
    fetch(1, "rst_acc1");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_data", 32'(rsp_data), 32'd0);
    chk("arst_addr", 32'(rsp_addr), 32'd0);
    chk("arst_err", 32'(rsp_err), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    prog_mode = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("arst_load", 32'(req_ready), 32'd0);
    tick();
    prog_mode = 1'b0;
    tick();

    // Memory contents survive reset.
    rsp_ready = 1'b1;
    fetch(2, "post_rst_acc");
    tick();

`ifdef INSTMEM_PARITY_EN
    dut.mem[1][0] = ~dut.mem[1][0];
    req_valid = 1'b1;
    req_addr = 6'd1;
    @(negedge clk);
    chk("par_acc1", 32'(req_ready), 32'd1);
    e = mk(1);
    e.data = 8'h23;
    e.perr = 1'b1;
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
    fetch(0, "par_acc0");
    tick();
`endif
    e = mk(0);

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
